mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and scheduler that shares one 4:1 multiplexed output channel among four requesters.
- Produces the 2-bit select and the one-hot grant for the 4:1 mux datapath.
- Registers the selected data word.
- Enforces a bounded hold time so that no requester can starve the others.
- Sits between four producer blocks and a single shared downstream consumer.

Parameters:
DW, 8, width of each requester data word
MAX_HOLD, 4, maximum consecutive grant cycles before forced rotation when another requester is pending (legal range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester (level); req[i] high = requester i wants the channel
in  input  4*DW  data words; requester i occupies in[i*DW +: DW]
grant  output  4  one-hot grant, registered; all zero when idle
sel  output  2  mux select = index of current owner, registered; holds last owner when idle
valid  output  1  high while any grant is active (OR of grant)
out  output  DW  registered data: in word of the owner, captured each cycle valid is high; 0 when idle
hold_cnt  output  8  consecutive cycles the current owner has held the grant, saturating at MAX_HOLD

Behaviour:
- Reset (rst_n low, asynchronous): grant=0, sel=0, valid=0, out=0, hold_cnt=0, priority pointer ptr=0, state=IDLE.
- ptr[1:0] is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first asserted req in that order wins.
- State IDLE:
  - If req==0, remain in IDLE; outputs stay idle.
  - Otherwise, at the clock edge, grant the winner w: grant=1<<w, sel=w, hold_cnt=1, state=GRANT.
  - Latency: req sampled high at edge N gives grant high after edge N (one cycle).
- State GRANT, owner o:
  - Release: req[o] sampled low.
    - If other requests are pending, hand off at the same edge to the winner searched from ptr=o+1. No idle gap; hold_cnt=1.
    - If no other request is pending, go to IDLE with grant=0.
    - In both cases ptr=o+1.
  - Preemption: req[o] still high, hold_cnt==MAX_HOLD, and any req[j] (j≠o) is high. Hand off to the winner searched from o+1 (o excluded); ptr=o+1; hold_cnt=1.
  - No contention: req[o] high and no other request. Keep the grant; hold_cnt increments, saturating at MAX_HOLD.
  - Otherwise keep the grant and increment hold_cnt.
- ptr updates only when a grant ends (release or preemption). It does not update on a fresh grant from IDLE.
- out: at each edge where the next state has a grant, out <= in word of the next owner. Otherwise out <= 0. This makes out aligned with grant and sel in the same cycle.
- valid == |grant at all times; grant is always zero or one-hot.
- Simultaneous requests from IDLE are resolved purely by ptr order.
- Simultaneous release by the owner and a new request are handled as a release with handoff.
- Changes on req between edges have no effect; only values sampled at edges matter.
- Reset mid-grant: all outputs drop immediately and asynchronously. After rst_n deasserts, arbitration restarts with ptr=0.
- MAX_HOLD=1: the owner rotates every cycle whenever another requester is pending.

Test Plan:
- Reset: assert rst_n=0 mid-grant with req=4'b1111 -> grant=0, sel=0, out=0, hold_cnt=0 immediately; after release, the first grant goes to requester 0.
- Single requester: req=4'b0100, in word2=8'hA5 -> one cycle later grant=4'b0100, sel=2, out=8'hA5. After 10 cycles grant is still held and hold_cnt=4. After req drops, the next cycle is idle, grant=0, out=0.
- Round robin: req=4'b1111 held, MAX_HOLD=4 -> owners are 0,1,2,3,0, each granted exactly 4 cycles; handoffs have no idle cycle.
- Early release: owner 1 drops req after 2 cycles while req[3] and req[0] are high -> the next edge grants 3 (searched from 2), hold_cnt=1.
- Pointer wrap: ptr=3 after owner 2 releases; req=4'b1001 arrives -> grant goes to 3; on its release, 0 is granted.
- MAX_HOLD=1 override with req=4'b0011 -> grant alternates 0,1,0,1 every cycle; out tracks the in words of the alternating owners.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 output channel.
// Drives the registered one-hot grant, mux select and captured data word, and
// forces rotation after MAX_HOLD consecutive cycles whenever another requester waits.
module mux4_rr_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] in,
    output logic [3:0]      grant,
    output logic [1:0]      sel,
    output logic            valid,
    output logic [DW-1:0]   out,
    output logic [7:0]      hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      grant_q, grant_d;
    logic [DW-1:0]   out_q, out_d;
    logic [7:0]      hold_q, hold_d;
    logic [3:0]      others;
    logic [2:0]      pick;

    // First asserted request scanning base, base+1, ... (mod 4); returns {found, index}
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!res[2] && r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // State register: all arbiter flops with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            out_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            out_q   <= out_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic: pick owner, apply release/preemption, advance pointer and hold count
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        others  = req & ~grant_q;
        pick    = '0;
        case (state_q)
            IDLE: begin
                pick = rr_pick(req, ptr_q);
                if (pick[2]) begin
                    state_d = GRANT;
                    sel_d   = pick[1:0];
                    hold_d  = 8'd1;
                end
            end
            GRANT: begin
                // Release and preemption share one path: scanning from owner+1 over the
                // other requesters never returns the current owner.
                if (!req[sel_q] || (hold_q == MAX_HOLD_C && |others)) begin
                    ptr_d = sel_q + 2'd1;
                    pick  = rr_pick(others, sel_q + 2'd1);
                    if (pick[2]) begin
                        sel_d  = pick[1:0];
                        hold_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end else if (hold_q < MAX_HOLD_C) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: registered grant/data follow the next owner; ports mirror the flops
    always_comb begin
        grant_d = '0;
        out_d   = '0;
        if (state_d == GRANT) begin
            grant_d = 4'b0001 << sel_d;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sel_d == 2'(i)) out_d = in[i*DW +: DW];
            end
        end
        grant    = grant_q;
        sel      = sel_q;
        valid    = |grant_q;
        out      = out_q;
        hold_cnt = hold_q;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1) checked every
// cycle against a behavioural round-robin model, plus hand-computed directed checks.
module tb_mux4_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req0, req1;
    logic [31:0] in0, in1;
    logic [3:0]  grant0, grant1;
    logic [1:0]  sel0, sel1;
    logic        valid0, valid1;
    logic [7:0]  out0, out1;
    logic [7:0]  hold0, hold1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req0), .in(in0),
        .grant(grant0), .sel(sel0), .valid(valid0), .out(out0), .hold_cnt(hold0)
    );

    mux4_rr_arbiter #(.DW(8), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .in(in1),
        .grant(grant1), .sel(sel1), .valid(valid1), .out(out1), .hold_cnt(hold1)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_owner[2] = '{-1, -1};
    int m_ptr[2]   = '{0, 0};
    int m_sel[2]   = '{0, 0};
    int m_hold[2]  = '{0, 0};
    int m_out[2]   = '{0, 0};

    function automatic int pick(input logic [3:0] r, input int base);
        for (int i = 0; i < 4; i++) begin
            if (r[(base + i) % 4]) return (base + i) % 4;
        end
        return -1;
    endfunction

    task automatic step(input int k, input logic [3:0] r, input logic [31:0] w, input int mh);
        int o;
        logic [3:0] rest;
        o = m_owner[k];
        if (o < 0) begin
            o = pick(r, m_ptr[k]);
            if (o >= 0) m_hold[k] = 1;
        end else begin
            rest = r;
            rest[o] = 1'b0;
            if (!r[o] || (m_hold[k] == mh && rest != 0)) begin
                m_ptr[k] = (o + 1) % 4;
                o = pick(rest, m_ptr[k]);
                m_hold[k] = (o >= 0) ? 1 : 0;
            end else if (m_hold[k] < mh) begin
                m_hold[k] = m_hold[k] + 1;
            end
        end
        m_owner[k] = o;
        if (o >= 0) begin
            m_sel[k] = o;
            m_out[k] = int'(w >> (8 * o)) & 'hFF;
        end else begin
            m_out[k] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_owner[k] = -1; m_ptr[k] = 0; m_sel[k] = 0; m_hold[k] = 0; m_out[k] = 0;
            end
        end else begin
            step(0, req0, in0, 4);
            step(1, req1, in1, 1);
        end
    end

    function automatic int exp_grant(input int k);
        return (m_owner[k] < 0) ? 0 : (1 << m_owner[k]);
    endfunction

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("m4.grant", int'(grant0), exp_grant(0));
        check("m4.sel",   int'(sel0),   m_sel[0]);
        check("m4.valid", int'(valid0), int'(m_owner[0] >= 0));
        check("m4.out",   int'(out0),   m_out[0]);
        check("m4.hold",  int'(hold0),  m_hold[0]);
        check("m1.grant", int'(grant1), exp_grant(1));
        check("m1.sel",   int'(sel1),   m_sel[1]);
        check("m1.valid", int'(valid1), int'(m_owner[1] >= 0));
        check("m1.out",   int'(out1),   m_out[1]);
        check("m1.hold",  int'(hold1),  m_hold[1]);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        rst_n = 1'b1;
        req0  = '0;
        req1  = '0;
        in0   = {8'h44, 8'hA5, 8'h22, 8'h11};
        in1   = {8'h00, 8'h00, 8'h3C, 8'hC3};
        #2 rst_n = 1'b0;
        tick; tick;
        check("rst.grant", int'(grant0), 0);
        check("rst.out",   int'(out0),   0);
        check("rst.hold",  int'(hold0),  0);
        rst_n = 1'b1;
        tick;

        // single requester 2
        req0 = 4'b0100;
        tick;
        check("single.grant", int'(grant0), 4'b0100);
        check("single.sel",   int'(sel0),   2);
        check("single.out",   int'(out0),   8'hA5);
        check("single.hold1", int'(hold0),  1);
        repeat (9) tick;
        check("single.held", int'(grant0), 4'b0100);
        check("single.sat",  int'(hold0),  4);
        req0 = 4'b0000;
        tick;
        check("single.idle_grant", int'(grant0), 0);
        check("single.idle_out",   int'(out0),   0);
        check("single.idle_valid", int'(valid0), 0);
        check("single.idle_sel",   int'(sel0),   2);

        // pointer wrap: ptr is 3 after owner 2 released
        req0 = 4'b1001;
        tick;
        check("wrap.grant3", int'(grant0), 4'b1000);
        check("wrap.sel3",   int'(sel0),   3);
        req0 = 4'b0001;
        tick;
        check("wrap.grant0", int'(grant0), 4'b0001);
        check("wrap.out0",   int'(out0),   8'h11);
        req0 = 4'b0000;
        tick;

        // reset mid-grant (ptr is 1 here, so requester 1 wins first)
        req0 = 4'b1111;
        tick;
        check("pre_rst.grant1", int'(grant0), 4'b0010);
        tick;
        rst_n = 1'b0;
        #1;
        check("async_rst.grant", int'(grant0), 0);
        check("async_rst.sel",   int'(sel0),   0);
        check("async_rst.out",   int'(out0),   0);
        check("async_rst.hold",  int'(hold0),  0);
        check("async_rst.valid", int'(valid0), 0);
        tick;
        rst_n = 1'b1;

        // round robin with all four requesting, from ptr=0
        tick;
        check("rr.first", int'(grant0), 4'b0001);
        check("rr.first_hold", int'(hold0), 1);
        for (int k = 1; k < 20; k++) begin
            tick;
            check("rr.grant", int'(grant0), 1 << ((k / 4) % 4));
            check("rr.hold",  int'(hold0),  (k % 4) + 1);
        end

        // early release of owner 1 after two cycles
        tick;
        check("early.own1", int'(grant0), 4'b0010);
        tick;
        check("early.hold2", int'(hold0), 2);
        req0 = 4'b1001;
        tick;
        check("early.grant3", int'(grant0), 4'b1000);
        check("early.hold1",  int'(hold0),  1);
        check("early.out",    int'(out0),   8'h44);
        req0 = 4'b0000;
        tick;
        check("early.idle", int'(valid0), 0);

        // MAX_HOLD=1 instance alternates every cycle
        req1 = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("mh1.grant", int'(grant1), (k % 2 == 0) ? 1 : 2);
            check("mh1.out",   int'(out1),   (k % 2 == 0) ? 8'hC3 : 8'h3C);
            check("mh1.hold",  int'(hold1),  1);
        end
        req1 = 4'b0000;
        tick; tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
